iterative_alu: RTL and testbench

Parametrised, multi-cycle successor to the 64-bit combinational ALU in the RISC-V CPU datapath.
- Keeps the existing single-cycle ops: AND, OR, ADD, SUB.
- Adds XOR, SLT, SLTU and iterative MUL, DIVU and REMU (shift-add multiplier, restoring divider).
- Uses valid/ready handshakes on both the operand side and the result side so the execute stage can stall on long ops.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/iterative_alu.sv | 204 ++++++++++++++++++++
 tb/tb_iterative_alu.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM state encoding and helpers for the
//               iterative ALU and its multiply/divide datapath.
//               Optional macro ITERATIVE_ALU_SIGNED_DIV_EN makes the signed
//               DIV/REM codes iterative operations.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SLTU    = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_MUL     = 4'b1000;
    localparam logic [3:0] ALU_DIVU    = 4'b1001;
    localparam logic [3:0] ALU_REMU    = 4'b1010;
    localparam logic [3:0] ALU_DIV     = 4'b1011;
    localparam logic [3:0] ALU_REM     = 4'b1101;
    // Internal code substituted for any opcode with nonzero upper control bits
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for opcodes that run on the multi-cycle multiply/divide datapath
    function automatic logic is_iter_op(input logic [3:0] op);
        logic r;
        r = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`ifdef ITERATIVE_ALU_SIGNED_DIV_EN
        r = r || (op == ALU_DIV) || (op == ALU_REM);
`endif
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : One-bit-per-cycle shift-add multiplier and restoring
//               divider. start loads operands and the iteration counter;
//               done is high during the final iteration, and the result
//               outputs present the values being written at that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_in,     // multiplicand / dividend
    input  logic [XLEN-1:0] b_in,     // multiplier / divisor
    output logic            done,
    output logic [XLEN-1:0] prod,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [XLEN-1:0]  acc_q, acc_d;   // product accumulator
    logic [XLEN-1:0]  rem_q, rem_d;   // partial remainder
    logic [XLEN-1:0]  quo_q, quo_d;   // multiplier bits (mul) / dividend->quotient (div)
    logic [XLEN-1:0]  opb_q, opb_d;   // shifting multiplicand (mul) / divisor (div)
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;

    // Next-state for one iteration: add-and-shift for MUL, trial subtract for DIV
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        opb_d   = opb_q;
        w_shift = {rem_q, quo_q[XLEN-1]};
        w_trial = w_shift - {1'b0, opb_q};
        if (start) begin
            cnt_d = CNT_W'(XLEN);
            div_d = is_div;
            acc_d = '0;
            rem_d = '0;
            quo_d = is_div ? a_in : b_in;
            opb_d = is_div ? b_in : a_in;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                // A zero divisor always "fits", yielding all-ones quotient and rem = dividend
                if (!w_trial[XLEN]) begin
                    rem_d = w_trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = w_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                if (quo_q[0]) begin
                    acc_d = acc_q + opb_q;
                end
                opb_d = opb_q << 1;
                quo_d = quo_q >> 1;
            end
        end
    end

    // Datapath registers; reset abandons any iteration in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            opb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            opb_q <= opb_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));
    assign prod = acc_d;
    assign quo  = quo_d;
    assign rem  = rem_d;

endmodule
`default_nettype wire

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : iterative_alu
// Description : Multi-cycle ALU with valid/ready handshakes on operands and
//               result. Single-cycle logic/add ops complete in one cycle;
//               MUL/DIVU/REMU iterate XLEN cycles on alu_muldiv_iter.
//               Macro ITERATIVE_ALU_SIGNED_DIV_EN adds signed DIV/REM.
//               XLEN must be a power of two >= 8; CTRL_W must be >= 4.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_alu
    import alu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   X,
    input  logic [XLEN-1:0]   Y,
    input  logic [CTRL_W-1:0] aluControl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   aluOut,
    output logic              zero,
    output logic              busy
);

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [3:0]      op_q, op_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            w_hi_ok;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_single, w_iter_res;
    logic [XLEN-1:0] w_md_a, w_md_b, w_prod, w_quo, w_rem;
    logic            w_qneg, w_rneg, w_start, w_done;

    // Control bits above the 4-bit opcode field must be zero for a legal code
    generate
        if (CTRL_W > 4) begin : g_ctrl_wide
            assign w_hi_ok = (aluControl[CTRL_W-1:4] == '0);
        end else begin : g_ctrl_narrow
            assign w_hi_ok = 1'b1;
        end
    endgenerate

    assign w_op = w_hi_ok ? aluControl[3:0] : ALU_ILLEGAL;

    // Single-cycle results; unlisted codes give zero
    always_comb begin
        case (w_op)
            ALU_AND:  w_single = X & Y;
            ALU_OR:   w_single = X | Y;
            ALU_ADD:  w_single = X + Y;
            ALU_XOR:  w_single = X ^ Y;
            ALU_SUB:  w_single = X - Y;
            ALU_SLT:  w_single = {{(XLEN-1){1'b0}}, ($signed(X) < $signed(Y))};
            ALU_SLTU: w_single = {{(XLEN-1){1'b0}}, (X < Y)};
            default:  w_single = '0;
        endcase
    end

    // Divider operands: magnitudes plus result-sign flags for signed divide
    always_comb begin
        w_md_a = X;
        w_md_b = Y;
        w_qneg = 1'b0;
        w_rneg = 1'b0;
`ifdef ITERATIVE_ALU_SIGNED_DIV_EN
        if ((w_op == ALU_DIV) || (w_op == ALU_REM)) begin
            w_md_a = X[XLEN-1] ? -X : X;
            w_md_b = Y[XLEN-1] ? -Y : Y;
            // Divide-by-zero keeps the all-ones quotient unsigned-style
            w_qneg = (X[XLEN-1] ^ Y[XLEN-1]) && (Y != '0);
            w_rneg = X[XLEN-1];
        end
`endif
    end

    assign w_start = (state_q == ST_IDLE) && in_valid && is_iter_op(w_op);

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_op != ALU_MUL),
        .a_in   (w_md_a),
        .b_in   (w_md_b),
        .done   (w_done),
        .prod   (w_prod),
        .quo    (w_quo),
        .rem    (w_rem)
    );

    // Select and sign-fix the iterative result for the captured opcode
    always_comb begin
        case (op_q)
            ALU_MUL:  w_iter_res = w_prod;
            ALU_DIVU: w_iter_res = w_quo;
            ALU_REMU: w_iter_res = w_rem;
            ALU_DIV:  w_iter_res = qneg_q ? -w_quo : w_quo;
            ALU_REM:  w_iter_res = rneg_q ? -w_rem : w_rem;
            default:  w_iter_res = '0;
        endcase
    end

    // FSM next-state and registered handshake/result outputs
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        zero_d      = zero_q;
        alu_out_d   = alu_out_q;
        op_d        = op_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d       = w_op;
                    qneg_d     = w_qneg;
                    rneg_d     = w_rneg;
                    in_ready_d = 1'b0;
                    if (is_iter_op(w_op)) begin
                        state_d = ST_ITER;
                        busy_d  = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        alu_out_d   = w_single;
                        zero_d      = (w_single == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (w_done) begin
                    state_d     = ST_DONE;
                    alu_out_d   = w_iter_res;
                    zero_d      = (w_iter_res == '0);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            zero_q      <= 1'b1;
            alu_out_q   <= '0;
            op_q        <= ALU_AND;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            zero_q      <= zero_d;
            alu_out_q   <= alu_out_d;
            op_q        <= op_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign zero      = zero_q;
    assign aluOut    = alu_out_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_alu
// Description : Scoreboard bench for iterative_alu. A driver issues ops and
//               pushes reference results; a monitor pops and compares on
//               each result handshake and checks latency and hold behaviour.
//               Honours macro ITERATIVE_ALU_SIGNED_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

    localparam int XLEN = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] val;
        logic        zero;
        int          lat;
        bit          iter;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] X;
    logic [XLEN-1:0] Y;
    logic [3:0]      aluControl;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] aluOut;
    logic            zero;
    logic            busy;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ov_cnt   = 0;
    logic        force_or  = 1'b1;
    logic        force_val = 1'b1;

    iterative_alu #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .X          (X),
        .Y          (Y),
        .aluControl (aluControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluOut     (aluOut),
        .zero       (zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Result-side consumer: directed level or random backpressure
    always @(posedge clk) begin
        #1;
        out_ready = force_or ? force_val : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic bit tb_is_iter(input logic [3:0] op);
        bit r;
        r = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
`ifdef ITERATIVE_ALU_SIGNED_DIV_EN
        r = r || (op == 4'hB) || (op == 4'hD);
`endif
        return r;
    endfunction

    // Reference behaviour from plain arithmetic with RISC-V corner rules
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h6: return a - b;
            4'h7: return (sa < sb) ? 64'd1 : 64'd0;
            4'h5: return (a < b) ? 64'd1 : 64'd0;
            4'h8: return a * b;
            4'h9: begin
                if (b == 64'd0) return '1;
                return a / b;
            end
            4'hA: begin
                if (b == 64'd0) return a;
                return a % b;
            end
`ifdef ITERATIVE_ALU_SIGNED_DIV_EN
            4'hB: begin
                if (b == 64'd0) return '1;
                if (a == MINV && b == '1) return MINV;
                return 64'(sa / sb);
            end
            4'hD: begin
                if (b == 64'd0) return a;
                if (a == MINV && b == '1) return 64'd0;
                return 64'(sa % sb);
            end
`endif
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return MINV;
            3:       return 64'($urandom_range(0, 255));
            4:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Must be called just after a rising edge; returns after the accept edge
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, output int waited);
        exp_t e;
        waited     = 0;
        X          = a;
        Y          = b;
        aluControl = op;
        in_valid   = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) begin
                fail_now("issue_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        e.val  = model(op, a, b);
        e.zero = (e.val == 64'd0);
        e.iter = tb_is_iter(op);
        e.lat  = e.iter ? XLEN + 1 : 1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        X          = {$urandom, $urandom};
        Y          = {$urandom, $urandom};
        aluControl = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency, hold-while-stalled, and scoreboard compare on handshake
    int          acc_cyc  = 0;
    bit          inflight = 0;
    bit          ov_seen  = 0;
    logic [63:0] held;
    exp_t        got;
    always @(negedge clk) begin
        if (!rst_n) begin
            inflight = 0;
            ov_seen  = 0;
        end else begin
            if (out_valid) begin
                if (!ov_seen) begin
                    ov_cnt++;
                    if (sbq.size() == 0) fail_now("unexpected_out");
                    else chk("latency", 64'(cyc + 1 - acc_cyc), 64'(sbq[0].lat));
                    held    = aluOut;
                    ov_seen = 1;
                end else begin
                    chk("out_hold", aluOut, held);
                end
                chk("in_ready_done", in_ready, 0);
                chk("busy_done", busy, 0);
                if (out_ready && sbq.size() != 0) begin
                    got = sbq.pop_front();
                    chk("aluOut", aluOut, got.val);
                    chk("zero", zero, got.zero);
                    ov_seen  = 0;
                    inflight = 0;
                end
            end else if (inflight) begin
                chk("in_ready_iter", in_ready, 0);
                if (sbq.size() != 0 && sbq[0].iter) chk("busy_iter", busy, 1);
            end
            if (in_valid && in_ready) begin
                inflight = 1;
                acc_cyc  = cyc + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int ovc;
        logic [3:0] op;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        X          = '0;
        Y          = '0;
        aluControl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aluOut", aluOut, 0);
        chk("rst_zero", zero, 1);
        rst_n = 1'b1;

        // Directed operations
        issue(4'h0, 64'hAAAA, 64'h0110, w);
        issue(4'h6, 64'd128, 64'd64, w);
        issue(4'h6, 64'd5, 64'd7, w);
        issue(4'h7, '1, 64'd1, w);
        issue(4'h5, '1, 64'd1, w);
        issue(4'h3, 64'hF0F0, 64'h0FF0, w);
        issue(4'h2, '1, 64'd2, w);
        issue(4'h8, 64'd123, 64'd321, w);
        issue(4'h9, 64'd12345, 64'd100, w);
        issue(4'hA, 64'd12345, 64'd100, w);
        issue(4'h9, 64'd7, 64'd0, w);
        issue(4'hA, 64'd7, 64'd0, w);
        issue(4'hB, -64'sd7, 64'd2, w);
        issue(4'hD, -64'sd7, 64'd2, w);
        issue(4'hB, MINV, '1, w);
        issue(4'hD, MINV, '1, w);
        issue(4'hF, 64'd5, 64'd5, w);
        drain();

        // Backpressure: hold out_ready low, then release and reissue at once
        force_or  = 1'b1;
        force_val = 1'b0;
        @(posedge clk);
        #1;
        issue(4'h2, 64'd40, 64'd2, w);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("bp_out_valid_timeout");
        repeat (3) @(negedge clk);
        force_val = 1'b1;
        n = 0;
        while (!(out_valid && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("bp_release_timeout");
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", in_ready, 1);
        issue(4'h1, 64'h1200, 64'h0034, w);
        chk("bp_next_accept_wait", 64'(w), 64'd0);
        drain();

        // Randomized traffic with random backpressure
        force_or = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, rand_opnd(), rand_opnd(), w);
        end
        drain();

        // Reset in the middle of a multiply abandons it
        force_or  = 1'b1;
        force_val = 1'b1;
        @(posedge clk);
        #1;
        issue(4'h8, {$urandom, $urandom}, {$urandom, $urandom}, w);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_aluOut", aluOut, 0);
        chk("rstmid_zero", zero, 1);
        sbq.delete();
        rst_n = 1'b1;
        ovc   = ov_cnt;
        repeat (80) @(posedge clk);
        #1;
        chk("rstmid_no_stale", 64'(ov_cnt), 64'(ovc));
        issue(4'hA, 64'd100, 64'd7, w);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
